output_tile_buffer: RTL and testbench

- Parametrised successor to the matrix multiplier output register: collects ROWS result rows of COLS elements each, then drains the finished tile one element per cycle to a downstream consumer.
- Replaces the monolithic shift register with row-indexed storage, valid/ready handshakes on both sides, selectable row-major or column-major (transposed) drain order, and a synchronous abort.
- Sits between the multiplier array row output and the result write-back path.

---
 rtl/mm_pkg.sv | 21 ++
 rtl/tile_drain_counter.sv | 58 +++++
 rtl/output_tile_buffer.sv | 121 ++++++++++++
 tb/tb_output_tile_buffer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix multiplier output path: element width,
// tile buffer states and index-width helper.
package mm_pkg;

  localparam int ELEM_W_DEFAULT = 32;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Index width for a dimension; a single-entry dimension still needs one bit.
  function automatic int clog2_min1(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/tile_drain_counter.sv
// Two-level row/column index counter used to walk a finished tile in either
// row-major (mode=0) or column-major (mode=1) order.
module tile_drain_counter
  import mm_pkg::*;
#(
  parameter  int ROWS = 128,
  parameter  int COLS = 128,
  localparam int RW   = clog2_min1(ROWS),
  localparam int CW   = clog2_min1(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          zero,
  input  logic          advance,
  input  logic          mode,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic row_wrap;
  logic col_wrap;

  assign row_wrap = (row == ROW_MAX);
  assign col_wrap = (col == COL_MAX);
  assign last     = row_wrap && col_wrap;

  // Index update: the inner dimension wraps into the outer one.
  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (zero) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (mode == 1'b0) begin
        if (col_wrap) begin
          col <= '0;
          row <= row_wrap ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end else begin
        if (row_wrap) begin
          row <= '0;
          col <= col_wrap ? '0 : col + CW'(1);
        end else begin
          row <= row + RW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/output_tile_buffer.sv
// Collects ROWS result rows from the multiplier array, then drains the tile
// one element per cycle in row-major or transposed order.
module output_tile_buffer
  import mm_pkg::*;
#(
  parameter  int ELEM_W = ELEM_W_DEFAULT,
  parameter  int COLS   = 128,
  parameter  int ROWS   = 128,
  localparam int RW     = clog2_min1(ROWS),
  localparam int CW     = clog2_min1(COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COLS*ELEM_W-1:0] in_row,
  input  logic                   transpose,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ELEM_W-1:0]      out_data,
  output logic [RW-1:0]          out_row,
  output logic [CW-1:0]          out_col,
  output logic                   out_last,
  output logic                   done
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

  state_t            state;
  state_t            next_state;
  logic [RW-1:0]     row_cnt;
  logic              drain_mode;
  logic              accept;
  logic              last_row;
  logic              fire;
  logic              cnt_last;
  logic              tile_end;
  logic [ELEM_W-1:0] storage [ROWS][COLS];

  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  assign accept    = in_valid && in_ready;
  assign last_row  = accept && (row_cnt == ROW_MAX);
  assign fire      = out_valid && out_ready;
  assign tile_end  = fire && cnt_last;
  assign out_last  = out_valid && cnt_last;

  // Drain walk; a fresh tile always starts from (0,0).
  tile_drain_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_drain_counter (
    .clk     (clk),
    .rst     (rst),
    .zero    (clear || last_row),
    .advance (fire),
    .mode    (drain_mode),
    .row     (out_row),
    .col     (out_col),
    .last    (cnt_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; clear returns to FILL from anywhere.
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = FILL;
    end else begin
      case (state)
        FILL:    next_state = last_row ? DRAIN : FILL;
        DRAIN:   next_state = tile_end ? FILL : DRAIN;
        default: next_state = FILL;
      endcase
    end
  end

  // Row counter, drain order latch and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt    <= '0;
      drain_mode <= 1'b0;
      done       <= 1'b0;
    end else if (clear) begin
      row_cnt    <= '0;
      done       <= 1'b0;
    end else begin
      done <= tile_end;
      if (accept) begin
        row_cnt <= last_row ? '0 : row_cnt + RW'(1);
      end
      if (last_row) begin
        drain_mode <= transpose;
      end
    end
  end

  // Row storage; element 0 arrives in the MSBs of in_row.
  always_ff @(posedge clk) begin
    if (!rst && !clear && accept) begin
      for (int c = 0; c < COLS; c++) begin
        storage[row_cnt][c] <= in_row[ELEM_W*(COLS-1-c) +: ELEM_W];
      end
    end
  end

  // Element read from registered indices.
  always_comb begin
    out_data = storage[out_row][out_col];
  end

endmodule

// File: tb/tb_output_tile_buffer.sv
// Scoreboard bench: a 4x4 and a 3x5 instance (8-bit elements); expected drain
// sequences are queued at fill time and popped on each transfer.
module tb_output_tile_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, clear = 1'b0, in_valid = 1'b0, transpose = 1'b0, out_ready = 1'b0;
  int          sel = 0;
  logic [31:0] row_a = '0;
  logic [39:0] row_b = '0;

  logic       in_ready_a, out_valid_a, out_last_a, done_a;
  logic [7:0] out_data_a;
  logic [1:0] out_row_a, out_col_a;
  logic       in_ready_b, out_valid_b, out_last_b, done_b;
  logic [7:0] out_data_b;
  logic [1:0] out_row_b;
  logic [2:0] out_col_b;

  output_tile_buffer #(.ELEM_W(8), .COLS(4), .ROWS(4)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid && (sel == 0)),
    .in_ready(in_ready_a), .in_row(row_a), .transpose(transpose),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_row(out_row_a), .out_col(out_col_a), .out_last(out_last_a), .done(done_a));

  output_tile_buffer #(.ELEM_W(8), .COLS(5), .ROWS(3)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid && (sel == 1)),
    .in_ready(in_ready_b), .in_row(row_b), .transpose(transpose),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_row(out_row_b), .out_col(out_col_b), .out_last(out_last_b), .done(done_b));

  logic       obs_in_ready, obs_out_valid, obs_out_last, obs_done;
  logic [7:0] obs_data;
  logic [2:0] obs_row, obs_col;

  always_comb begin
    if (sel == 1) begin
      obs_in_ready = in_ready_b; obs_out_valid = out_valid_b; obs_out_last = out_last_b;
      obs_done = done_b; obs_data = out_data_b; obs_row = {1'b0, out_row_b}; obs_col = out_col_b;
    end else begin
      obs_in_ready = in_ready_a; obs_out_valid = out_valid_a; obs_out_last = out_last_a;
      obs_done = done_a; obs_data = out_data_a; obs_row = {1'b0, out_row_a}; obs_col = {1'b0, out_col_a};
    end
  end

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] d;
    int         r;
    int         c;
    logic       l;
  } exp_t;
  exp_t sb[$];

  function automatic int nrows();
    return (sel == 1) ? 3 : 4;
  endfunction

  function automatic int ncols();
    return (sel == 1) ? 5 : 4;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int r, input int base);
    for (int c = 0; c < 4; c++) row_a[8*(3-c) +: 8] = 8'(base + 16*r + c);
    for (int c = 0; c < 5; c++) row_b[8*(4-c) +: 8] = 8'(base + 16*r + c);
  endtask

  task automatic fill(input int n, input int base, input logic tr);
    for (int r = 0; r < n; r++) begin
      set_row(r, base);
      in_valid  = 1'b1;
      transpose = (r == nrows() - 1) ? tr : ~tr;
      @(negedge clk);
      tests++;
      if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0) begin
        fails++;
        $display("FAIL fill_handshake row %0d: in_ready=%b out_valid=%b, expected 1/0",
                 r, obs_in_ready, obs_out_valid);
      end
      step();
    end
    in_valid  = 1'b0;
    transpose = 1'b0;
  endtask

  task automatic push_exp(input int base, input logic tr);
    int nr, nc;
    exp_t e;
    nr = nrows();
    nc = ncols();
    for (int i = 0; i < nr; i++) begin
      for (int j = 0; j < nc; j++) begin
        e.r = tr ? (j % nr) : i;
        e.c = tr ? (j / nr + i * (nc / nr)) : j;
      end
    end
    // Explicit order generation, independent of the index walk above
    if (!tr) begin
      for (int r = 0; r < nr; r++)
        for (int c = 0; c < nc; c++) begin
          e.r = r; e.c = c; e.d = 8'(base + 16*r + c); e.l = (r == nr-1) && (c == nc-1);
          sb.push_back(e);
        end
    end else begin
      for (int c = 0; c < nc; c++)
        for (int r = 0; r < nr; r++) begin
          e.r = r; e.c = c; e.d = 8'(base + 16*r + c); e.l = (r == nr-1) && (c == nc-1);
          sb.push_back(e);
        end
    end
  endtask

  task automatic drain(input bit bp);
    int         budget;
    bit         stalled;
    logic [7:0] held;
    exp_t       e;
    budget  = 2000;
    stalled = 1'b0;
    held    = '0;
    while (sb.size() > 0 && budget > 0) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      budget--;
      tests++;
      if (obs_out_valid !== 1'b1 || obs_done !== 1'b0 || obs_in_ready !== 1'b0) begin
        fails++;
        $display("FAIL drain_flags: out_valid=%b done=%b in_ready=%b, expected 1/0/0",
                 obs_out_valid, obs_done, obs_in_ready);
      end
      if (stalled) begin
        tests++;
        if (obs_data !== held) begin
          fails++;
          $display("FAIL stall_hold: data=%h, expected %h", obs_data, held);
        end
      end
      if (out_ready) begin
        e = sb.pop_front();
        tests++;
        if (obs_data !== e.d || obs_row !== 3'(e.r) || obs_col !== 3'(e.c) || obs_out_last !== e.l) begin
          fails++;
          $display("FAIL drain_elem: data=%h row=%0d col=%0d last=%b, expected %h %0d %0d %b",
                   obs_data, obs_row, obs_col, obs_out_last, e.d, e.r, e.c, e.l);
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = obs_data;
      end
      step();
    end
    tests++;
    if (budget == 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d elements left, expected 0", sb.size());
      sb.delete();
    end
    out_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (obs_done !== 1'b1 || obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL done_pulse: done=%b out_valid=%b in_ready=%b, expected 1/0/1",
               obs_done, obs_out_valid, obs_in_ready);
    end
    step();
    @(negedge clk);
    tests++;
    if (obs_done !== 1'b0) begin
      fails++;
      $display("FAIL done_width: done=%b, expected 0", obs_done);
    end
    step();
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    tests++;
    if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_out_last !== 1'b0 ||
        obs_done !== 1'b0 || obs_row !== 3'd0 || obs_col !== 3'd0) begin
      fails++;
      $display("FAIL %s: in_ready=%b out_valid=%b last=%b done=%b row=%0d col=%0d, expected 1 0 0 0 0 0",
               name, obs_in_ready, obs_out_valid, obs_out_last, obs_done, obs_row, obs_col);
    end
    step();
  endtask

  task automatic test_reset();
    sel = 0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_outputs("reset_a");
    sel = 1;
    check_reset_outputs("reset_b");
    sel = 0;
  endtask

  task automatic test_row_major();
    fill(4, 0, 1'b0);
    push_exp(0, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_col_major();
    fill(4, 0, 1'b1);
    push_exp(0, 1'b1);
    drain(1'b0);
  endtask

  task automatic test_backpressure();
    fill(4, 8'h40, 1'b0);
    push_exp(8'h40, 1'b0);
    drain(1'b1);
  endtask

  task automatic test_clear_fill();
    fill(2, 8'h80, 1'b0);
    set_row(2, 8'hC0);
    in_valid = 1'b1;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check_reset_outputs("clear_in_fill");
    fill(4, 8'h80, 1'b0);
    push_exp(8'h80, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_clear_drain();
    fill(4, 0, 1'b0);
    out_ready = 1'b1;
    step();
    step();
    step();
    out_ready = 1'b0;
    clear     = 1'b1;
    step();
    clear     = 1'b0;
    check_reset_outputs("clear_in_drain");
    @(negedge clk);
    tests++;
    if (obs_done !== 1'b0) begin
      fails++;
      $display("FAIL clear_no_done: done=%b, expected 0", obs_done);
    end
    step();
  endtask

  task automatic test_in_valid_during_drain();
    fill(4, 8'h20, 1'b0);
    push_exp(8'h20, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_row(i, 8'hF0);
      @(negedge clk);
      tests++;
      if (obs_in_ready !== 1'b0 || obs_out_valid !== 1'b1) begin
        fails++;
        $display("FAIL drain_blocks_input: in_ready=%b out_valid=%b, expected 0/1",
                 obs_in_ready, obs_out_valid);
      end
      step();
    end
    in_valid = 1'b0;
    drain(1'b0);
  endtask

  task automatic test_reset_mid_drain();
    fill(4, 0, 1'b1);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    rst       = 1'b1;
    step();
    rst       = 1'b0;
    check_reset_outputs("reset_in_drain");
  endtask

  task automatic test_non_pow2();
    sel = 1;
    fill(3, 0, 1'b0);
    push_exp(0, 1'b0);
    drain(1'b0);
    fill(3, 8'h60, 1'b1);
    push_exp(8'h60, 1'b1);
    drain(1'b1);
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_row_major();
    test_col_major();
    test_backpressure();
    test_clear_fill();
    test_clear_drain();
    test_in_valid_during_drain();
    test_reset_mid_drain();
    test_non_pow2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
